main_mem_responder: RTL

Main-memory responder at the far end of the cache miss interface: services line-fill reads from the instruction cache and line reads/writes from the data cache. While a cache miss is outstanding, the F stage (instruction cache) and C stage (data cache) hold their stall outputs (`icache_stall` / `dcache_stall`). This block is the memory side of those misses. It arbitrates between the two caches, models a fixed access latency, holds the backing line array, and returns one registered line per request with a single-cycle acknowledge. It sits beside `core_top` in the system top.

---
 rtl/main_mem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/main_mem_responder.sv
// Main-memory responder for I$ line fills and D$ line reads/writes.
// Fixed LATENCY cycles from accept to a one-cycle ack; requests are ignored while busy.
module main_mem_responder #(
  parameter int LINE_WORDS  = 4,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ic_req,
  input  logic [31:0]               ic_addr,
  output logic                      ic_ack,
  output logic [32*LINE_WORDS-1:0]  ic_rdata,
  input  logic                      dc_req,
  input  logic                      dc_we,
  input  logic [31:0]               dc_addr,
  input  logic [32*LINE_WORDS-1:0]  dc_wdata,
  output logic                      dc_ack,
  output logic [32*LINE_WORDS-1:0]  dc_rdata,
  output logic                      busy
);
  localparam int LW  = 32 * LINE_WORDS;
  localparam int OFS = $clog2(4 * LINE_WORDS);
  localparam int IDX = $clog2(DEPTH_LINES);
  localparam int CW  = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_port;        // 1 = dcache
  logic            r_last_grant;  // 1 = dcache
  logic            r_we;
  logic [IDX-1:0]  r_idx;
  logic [LW-1:0]   r_wdata;
  logic [LW-1:0]   r_ic_rdata;
  logic [LW-1:0]   r_dc_rdata;
  logic            r_ic_ack;
  logic            r_dc_ack;
  logic            r_busy;
  logic [LW-1:0]   r_mem [DEPTH_LINES];

  logic            w_grant_dc;
  logic            w_fire;
  logic [LW-1:0]   w_line;
  logic            w_unused;

  // On a tie the port not served last wins.
  assign w_grant_dc = dc_req & (~ic_req | ~r_last_grant);
  assign w_fire     = (r_state == S_WAIT) && (r_cnt == CW'(1));
  assign w_line     = r_mem[r_idx];
  assign w_unused   = ^{ic_addr[31:OFS+IDX], ic_addr[OFS-1:0],
                        dc_addr[31:OFS+IDX], dc_addr[OFS-1:0]};

  // Reset forces S_IDLE asynchronously, so a pending write is dropped with it.
  always_ff @(posedge clock) begin
    if (w_fire && r_we) r_mem[r_idx] <= r_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_port       <= 1'b0;
      r_last_grant <= 1'b0;
      r_we         <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
      r_ic_ack     <= 1'b0;
      r_dc_ack     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ic_ack <= 1'b0;
      r_dc_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ic_req || dc_req) begin
            r_port       <= w_grant_dc;
            r_last_grant <= w_grant_dc;
            r_idx        <= w_grant_dc ? dc_addr[OFS+IDX-1:OFS] : ic_addr[OFS+IDX-1:OFS];
            r_we         <= w_grant_dc & dc_we;
            r_wdata      <= dc_wdata;
            r_cnt        <= CW'(LATENCY - 1);
            r_busy       <= 1'b1;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_fire) begin
            if (r_port) begin
              r_dc_rdata <= w_line;
              r_dc_ack   <= 1'b1;
            end else begin
              r_ic_rdata <= w_line;
              r_ic_ack   <= 1'b1;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ic_ack   = r_ic_ack;
  assign dc_ack   = r_dc_ack;
  assign ic_rdata = r_ic_rdata;
  assign dc_rdata = r_dc_rdata;
  assign busy     = r_busy;
endmodule
